// File: rtl/inv_key_schedule_if.sv
// Handshake bundle for the AES-128 inverse key schedule.
// Carries start/key_last in, round keys out with valid/ready, plus busy/done.
interface inv_key_schedule_if;
    logic         start;
    logic [127:0] key_last;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    // Requester / key consumer side
    modport master (
        output start, key_last, rk_ready,
        input  busy, rk_valid, rk_round, rk_out, done
    );

    // Key schedule side
    modport slave (
        input  start, key_last, rk_ready,
        output busy, rk_valid, rk_round, rk_out, done
    );
endinterface

// File: rtl/inv_key_schedule.sv
// Sequential AES-128 inverse key schedule: emits round keys 10..0 from the
// round-10 key, deriving each earlier key on the fly.
// Ports: clk, rst (async, active-high), bus (slave modport of
// inv_key_schedule_if: start/key_last in, rk_* handshake out, busy, done).
module inv_key_schedule (
    input  logic              clk,
    input  logic              rst,
    inv_key_schedule_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state;
    state_t       w_next;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_done;

    logic         w_hs;
    logic         w_load;
    logic         w_step;
    logic         w_last;
    logic         w_valid;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_v0, w_v1, w_v2, w_v3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [127:0] w_prev;

    // Backward step: undo the forward recurrence word by word.
    // v3 must be formed first since it feeds the SubWord term of v0.
    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    assign w_v3 = w_w3 ^ w_w2;
    assign w_v2 = w_w2 ^ w_w1;
    assign w_v1 = w_w1 ^ w_w0;

    assign w_rot = {w_v3[23:0], w_v3[31:24]};
    assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]],
                    SBOX[w_rot[15:8]],  SBOX[w_rot[7:0]]};

    assign w_v0   = w_w0 ^ w_sub ^ {rcon(r_round), 24'h0};
    assign w_prev = {w_v0, w_v1, w_v2, w_v3};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.rk_ready && (r_round == 4'd0)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output / control decode, all from registered state
    always_comb begin
        w_valid = 1'b0;
        w_hs    = 1'b0;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = bus.start;
            end
            S_EMIT: begin
                w_valid = 1'b1;
                w_hs    = bus.rk_ready;
                w_step  = w_hs && (r_round != 4'd0);
                w_last  = w_hs && (r_round == 4'd0);
            end
            default: ;
        endcase
    end

    // Key register, round counter and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_key   <= bus.key_last;
                r_round <= 4'd10;
            end else if (w_step) begin
                r_key   <= w_prev;
                r_round <= r_round - 4'd1;
            end
        end
    end

    assign bus.rk_valid = w_valid;
    assign bus.busy     = w_valid;
    assign bus.rk_round = r_round;
    assign bus.rk_out   = r_key;
    assign bus.done     = r_done;

endmodule
